// File: rtl/aes_byte_display_ctrl.sv
// -----------------------------------------------------------------------------
// aes_byte_display_ctrl
//
// Sequencer for the binary-to-7-segment display path. It captures one
// NBYTES-byte AES block through a valid/ready handshake, presents one byte at
// a time to an external binary-to-BCD/7-segment converter (bin_o), and
// time-multiplexes four display digits:
//   digit 0 : ones of the selected byte     (an_o = 4'b1110)
//   digit 1 : tens of the selected byte     (an_o = 4'b1101)
//   digit 2 : hundreds of the selected byte (an_o = 4'b1011)
//   digit 3 : byte index as a hex character (an_o = 4'b0111)
//
// Build option:
//   AES_DISP_AUTO_ADVANCE_EN  when defined, the byte index advances by itself
//                             after DWELL complete 4-digit scan rotations.
//                             When undefined the index only moves on
//                             load/next/prev/clear.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   load_valid_i  in   block_i valid
//   load_ready_o  out  block accepted when load_valid_i & load_ready_o
//   block_i       in   8*NBYTES bits, byte k = block_i[8k+7:8k]
//   next_i        in   1-cycle pulse: advance index (wraps)
//   prev_i        in   1-cycle pulse: step index back (wraps)
//   clear_i       in   1-cycle pulse: return to IDLE, blank display
//   bin_o         out  selected byte, to converter input
//   idx_o         out  current byte index
//   hund_i        in   converter hundreds pattern (active-low gfedcba)
//   tens_i        in   converter tens pattern
//   ones_i        in   converter ones pattern
//   seg_o         out  segments, active-low gfedcba
//   an_o          out  digit enables, active-low one-hot, an_o[0] = ones
// -----------------------------------------------------------------------------
module aes_byte_display_ctrl #(
    parameter int NBYTES   = 16,
    parameter int SCAN_DIV = 50000,
    parameter int DWELL    = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [8*NBYTES-1:0]   block_i,
    input  logic                  next_i,
    input  logic                  prev_i,
    input  logic                  clear_i,
    output logic [7:0]            bin_o,
    output logic [3:0]            idx_o,
    input  logic [6:0]            hund_i,
    input  logic [6:0]            tens_i,
    input  logic [6:0]            ones_i,
    output logic [6:0]            seg_o,
    output logic [3:0]            an_o
);

    localparam int          SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0]  LAST_IDX = 4'(NBYTES - 1);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          idx_reg, idx_next;
    logic [7:0]          bin_reg, bin_next;
    logic [SCAN_W-1:0]   scan_cnt_reg, scan_cnt_next;
    logic [1:0]          digit_reg, digit_next;
    logic [6:0]          seg_reg, seg_next;
    logic [3:0]          an_reg, an_next;
    logic [7:0]          blk_reg [NBYTES];

    logic                accept;
    logic                scan_term;
    logic                step_fwd;
    logic                step_back;

`ifdef AES_DISP_AUTO_ADVANCE_EN
    localparam int DWELL_W = $clog2(DWELL + 1);
    logic [DWELL_W-1:0]  dwell_reg, dwell_next;
    logic                rot_wrap;
`endif

    // Ready is only withdrawn while a clear is being processed, so a clear
    // always beats a load arriving in the same cycle.
    assign load_ready_o = ~clear_i;
    assign accept       = load_valid_i & load_ready_o;

    assign scan_term = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
    // Simultaneous next and prev cancel each other.
    assign step_fwd  = next_i & ~prev_i;
    assign step_back = prev_i & ~next_i;

`ifdef AES_DISP_AUTO_ADVANCE_EN
    // One full rotation ends when the index digit reaches its terminal count.
    assign rot_wrap = scan_term & (digit_reg == 2'd3);
`endif

    assign bin_o = bin_reg;
    assign idx_o = idx_reg;
    assign seg_o = seg_reg;
    assign an_o  = an_reg;

    // Hex character decoder for the index digit (active-low gfedcba).
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] idx_inc(input logic [3:0] v);
        return (v == LAST_IDX) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] idx_dec(input logic [3:0] v);
        return (v == 4'd0) ? LAST_IDX : v - 4'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Block storage: every byte is written in the accept cycle.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_blk
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    blk_reg[gi] <= 8'd0;
                end else if (accept) begin
                    blk_reg[gi] <= block_i[8*gi +: 8];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= 4'd0;
            bin_reg      <= 8'd0;
            scan_cnt_reg <= '0;
            digit_reg    <= 2'd0;
            seg_reg      <= SEG_BLANK;
            an_reg       <= 4'hF;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            bin_reg      <= bin_next;
            scan_cnt_reg <= scan_cnt_next;
            digit_reg    <= digit_next;
            seg_reg      <= seg_next;
            an_reg       <= an_next;
        end
    end

`ifdef AES_DISP_AUTO_ADVANCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_reg <= '0;
        end else begin
            dwell_reg <= dwell_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: clear > load > next/prev > auto-advance.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        bin_next      = bin_reg;
        scan_cnt_next = scan_cnt_reg;
        digit_next    = digit_reg;
`ifdef AES_DISP_AUTO_ADVANCE_EN
        dwell_next    = dwell_reg;
`endif

        if (clear_i) begin
            state_next    = IDLE;
            idx_next      = 4'd0;
            bin_next      = 8'd0;
            scan_cnt_next = '0;
            digit_next    = 2'd0;
`ifdef AES_DISP_AUTO_ADVANCE_EN
            dwell_next    = '0;
`endif
        end else if (accept) begin
            // Byte 0 goes straight to bin so idx and bin agree right after load.
            state_next    = SHOW;
            idx_next      = 4'd0;
            bin_next      = block_i[7:0];
            scan_cnt_next = '0;
            digit_next    = 2'd0;
`ifdef AES_DISP_AUTO_ADVANCE_EN
            dwell_next    = '0;
`endif
        end else if (state_reg == SHOW) begin
            // Registered read of the selected byte: one cycle behind idx.
            bin_next = blk_reg[idx_reg];

            if (scan_term) begin
                scan_cnt_next = '0;
                digit_next    = digit_reg + 2'd1;
            end else begin
                scan_cnt_next = scan_cnt_reg + SCAN_W'(1);
            end

            if (next_i | prev_i) begin
`ifdef AES_DISP_AUTO_ADVANCE_EN
                dwell_next = '0;
`endif
                if (step_fwd) begin
                    idx_next = idx_inc(idx_reg);
                end else if (step_back) begin
                    idx_next = idx_dec(idx_reg);
                end
            end
`ifdef AES_DISP_AUTO_ADVANCE_EN
            else if (rot_wrap) begin
                if (dwell_reg == DWELL_W'(DWELL - 1)) begin
                    dwell_next = '0;
                    idx_next   = idx_inc(idx_reg);
                end else begin
                    dwell_next = dwell_reg + DWELL_W'(1);
                end
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Digit multiplexer. Blanked digits keep their anode enabled so every
    // digit sees the same refresh duty.
    // -------------------------------------------------------------------------
    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = 4'hF;

        if (!clear_i && (state_reg == SHOW)) begin
            case (digit_reg)
                2'd0: begin
                    seg_next = ones_i;
                    an_next  = 4'b1110;
                end
                2'd1: begin
                    seg_next = (bin_reg < 8'd10) ? SEG_BLANK : tens_i;
                    an_next  = 4'b1101;
                end
                2'd2: begin
                    seg_next = (bin_reg < 8'd100) ? SEG_BLANK : hund_i;
                    an_next  = 4'b1011;
                end
                default: begin
                    seg_next = hex7(idx_reg);
                    an_next  = 4'b0111;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_byte_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_byte_display_ctrl
//
// Self-checking bench for aes_byte_display_ctrl with SCAN_DIV=4, DWELL=3.
// A behavioural model (cycle count since display start, wrap count, byte
// array) predicts idx/bin/seg/an every cycle; a behavioural converter turns
// bin_o into hundreds/tens/ones patterns. Directed sequences are followed by
// randomized stimulus and a mid-scan reset.
// -----------------------------------------------------------------------------
module tb_aes_byte_display_ctrl;

    localparam int NB    = 16;
    localparam int SCAN  = 4;
    localparam int DW    = 3;
    localparam int ROT   = 4 * SCAN;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_valid_i;
    logic             load_ready_o;
    logic [8*NB-1:0]  block_i;
    logic             next_i;
    logic             prev_i;
    logic             clear_i;
    logic [7:0]       bin_o;
    logic [3:0]       idx_o;
    logic [6:0]       hund_i;
    logic [6:0]       tens_i;
    logic [6:0]       ones_i;
    logic [6:0]       seg_o;
    logic [3:0]       an_o;

    int n_vec = 0;
    int n_err = 0;
    int n_load = 0;

    always #5 clk = ~clk;

    aes_byte_display_ctrl #(
        .NBYTES   (NB),
        .SCAN_DIV (SCAN),
        .DWELL    (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .block_i      (block_i),
        .next_i       (next_i),
        .prev_i       (prev_i),
        .clear_i      (clear_i),
        .bin_o        (bin_o),
        .idx_o        (idx_o),
        .hund_i       (hund_i),
        .tens_i       (tens_i),
        .ones_i       (ones_i),
        .seg_o        (seg_o),
        .an_o         (an_o)
    );

    // Seven-segment character table, active-low gfedcba, 0-9 then A-F.
    function automatic logic [6:0] dec7(input int v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v % 16];
    endfunction

    // Behavioural stand-in for the external binary-to-7-segment converter.
    assign hund_i = dec7(int'(bin_o) / 100);
    assign tens_i = dec7((int'(bin_o) / 10) % 10);
    assign ones_i = dec7(int'(bin_o) % 10);

    // ---------------- reference model ----------------
    int         m_show, m_idx, m_bin, m_t, m_wraps;
    int         m_blk [NB];
    logic [6:0] m_seg;
    logic [3:0] m_an;

    task automatic model_reset();
        m_show = 0; m_idx = 0; m_bin = 0; m_t = 0; m_wraps = 0;
        m_seg = 7'h7F; m_an = 4'hF;
        for (int k = 0; k < NB; k++) m_blk[k] = 0;
    endtask

    // Predict the register contents after the coming clock edge.
    task automatic model_step(input logic v, input logic nx, input logic pv,
                              input logic cl, input logic [8*NB-1:0] blk);
        int  d;
        int  nbin;
        bit  ld;
        bit  wrap;
        ld = v && !cl;

        if (cl || m_show == 0) begin
            m_seg = 7'h7F;
            m_an  = 4'hF;
        end else begin
            d    = (m_t / SCAN) % 4;
            m_an = 4'hF ^ 4'(1 << d);
            case (d)
                0: m_seg = dec7(m_bin % 10);
                1: m_seg = (m_bin < 10)  ? 7'h7F : dec7((m_bin / 10) % 10);
                2: m_seg = (m_bin < 100) ? 7'h7F : dec7(m_bin / 100);
                default: m_seg = dec7(m_idx);
            endcase
        end

        if (cl)               nbin = 0;
        else if (ld)          nbin = int'(blk[7:0]);
        else if (m_show != 0) nbin = m_blk[m_idx];
        else                  nbin = m_bin;
        m_bin = nbin;

        wrap = (m_show != 0) && ((m_t % ROT) == ROT - 1);
        if (cl) begin
            m_show = 0; m_idx = 0; m_t = 0; m_wraps = 0;
        end else if (ld) begin
            m_show = 1; m_idx = 0; m_t = 0; m_wraps = 0;
            for (int k = 0; k < NB; k++) m_blk[k] = int'(blk[8*k +: 8]);
        end else if (m_show != 0) begin
            m_t++;
            if (nx || pv) begin
                m_wraps = 0;
                if (nx && !pv) m_idx = (m_idx + 1) % NB;
                if (pv && !nx) m_idx = (m_idx + NB - 1) % NB;
            end else begin
`ifdef AES_DISP_AUTO_ADVANCE_EN
                if (wrap) begin
                    m_wraps++;
                    if (m_wraps == DW) begin
                        m_wraps = 0;
                        m_idx = (m_idx + 1) % NB;
                    end
                end
`endif
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("idx_o", 32'(idx_o), 32'(m_idx));
        check("bin_o", 32'(bin_o), 32'(m_bin));
        check("seg_o", 32'(seg_o), 32'(m_seg));
        check("an_o",  32'(an_o),  32'(m_an));
    endtask

    // Drive one cycle of inputs, predict, advance one clock, compare.
    task automatic cycle(input logic v, input logic nx, input logic pv,
                         input logic cl, input logic [8*NB-1:0] blk);
        load_valid_i = v;
        next_i       = nx;
        prev_i       = pv;
        clear_i      = cl;
        block_i      = blk;
        #1;
        check("load_ready_o", 32'(load_ready_o), 32'(!cl));
        if (v && !cl) begin
            n_load++;
            $display("load %0d accepted at t=%0t, byte0=%0d", n_load, $time, blk[7:0]);
        end
        model_step(v, nx, pv, cl, blk);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, block_i);
    endtask

    function automatic logic [8*NB-1:0] rand_block();
        logic [8*NB-1:0] b;
        int corner [6];
        corner = '{0, 9, 10, 99, 100, 255};
        for (int k = 0; k < NB; k++) begin
            if ($urandom_range(0, 2) == 0) b[8*k +: 8] = 8'(corner[$urandom_range(0, 5)]);
            else                           b[8*k +: 8] = 8'($urandom_range(0, 255));
        end
        return b;
    endfunction

    logic [8*NB-1:0] pat;

    initial begin
        rst_n = 1'b0;
        load_valid_i = 1'b0; next_i = 1'b0; prev_i = 1'b0; clear_i = 1'b0;
        block_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst seg_o", 32'(seg_o), 32'h7F);
        check("rst an_o", 32'(an_o), 32'hF);
        check("rst idx_o", 32'(idx_o), 32'h0);
        check("rst bin_o", 32'(bin_o), 32'h0);
        check("rst load_ready_o", 32'(load_ready_o), 32'h1);
        rst_n = 1'b1;

        idle(5);

        // Directed block: 0, 7, 42, ... , 255
        for (int k = 0; k < NB; k++) pat[8*k +: 8] = 8'(k * 16 + 3);
        pat[7:0] = 8'd0; pat[15:8] = 8'd7; pat[23:16] = 8'd42; pat[127:120] = 8'd255;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, pat);
        check("load idx_o", 32'(idx_o), 32'h0);
        check("load bin_o", 32'(bin_o), 32'h0);
        idle(2 * ROT);

        for (int i = 0; i < NB - 1; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, pat);
            idle(1);
        end
        check("idx after 15 next", 32'(idx_o), 32'd15);
        idle(ROT);
        check("bin at idx 15", 32'(bin_o), 32'd255);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, pat);
        check("next wraps to 0", 32'(idx_o), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, pat);
        check("prev wraps to 15", 32'(idx_o), 32'd15);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, pat);
        check("next+prev hold", 32'(idx_o), 32'd15);
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, pat);
        check("load beats next", 32'(idx_o), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, pat);
        idle(ROT + 2);
        check("bin 7 at idx 1", 32'(bin_o), 32'd7);

        // Quiet stretch: auto-advance (when built in) runs across several bytes.
        idle(8 * DW * ROT);
        // Clear then reload restarts at index 0.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, pat);
        idle(10);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, pat);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_block());

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            logic v, nx, pv, cl;
            v  = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 99) == 0);
            nx = ($urandom_range(0, 9) == 0);
            pv = ($urandom_range(0, 9) == 0);
            if ((i / 400) % 2 == 1) begin
                nx = 1'b0; pv = 1'b0;
            end
            cycle(v, nx, pv, cl, rand_block());
        end

        // Mid-scan asynchronous reset.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, pat);
        idle(7);
        load_valid_i = 1'b0; next_i = 1'b0; prev_i = 1'b0; clear_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst seg_o", 32'(seg_o), 32'h7F);
        check("midrst an_o", 32'(an_o), 32'hF);
        check("midrst load_ready_o", 32'(load_ready_o), 32'h1);
        check("midrst idx_o", 32'(idx_o), 32'h0);
        check("midrst bin_o", 32'(bin_o), 32'h0);
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_block());
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  1'b0, block_i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
